// File: rtl/spiflash_reader.sv
// SPI flash byte reader: issues READ (0x03) with a 24-bit address and streams
// sequential bytes without a new command while the chip stays selected.
module spiflash_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        rden,
  input  logic        rd,
  input  logic [23:0] addr,
  output logic [7:0]  dout,
  output logic        data_valid,
  output logic        busy,
  output logic        flash_cs_n,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam int DIVW = $clog2(2 * CLK_DIV + 1);
  localparam int CSW  = $clog2(CS_HIGH_MIN + 1);
  localparam logic [DIVW-1:0] RISE    = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] FALL    = DIVW'(2 * CLK_DIV - 1);
  localparam logic [CSW-1:0]  CS_LAST = CSW'(CS_HIGH_MIN - 1);

  typedef enum logic [2:0] {IDLE, CMD, DATA, HOLD, DESEL} state_t;

  state_t            state;
  logic [DIVW-1:0]   div_cnt;
  logic [4:0]        bit_cnt;
  logic [31:0]       sh;
  logic [7:0]        rx;
  logic [23:0]       cur_addr;
  logic [23:0]       next_addr;
  logic [23:0]       pend_addr;
  logic              pend;
  logic [CSW-1:0]    cs_cnt;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      rx         <= '0;
      cur_addr   <= '0;
      next_addr  <= '0;
      pend_addr  <= '0;
      pend       <= 1'b0;
      cs_cnt     <= '0;
      dout       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      flash_cs_n <= 1'b1;
      flash_sck  <= 1'b0;
      flash_mosi <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (!rden && (state == CMD || state == DATA || state == HOLD)) begin
        // session closed: drop everything, the partial byte is never reported
        state      <= DESEL;
        flash_cs_n <= 1'b1;
        flash_sck  <= 1'b0;
        flash_mosi <= 1'b0;
        busy       <= 1'b0;
        pend       <= 1'b0;
        cs_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rd && rden) begin
              cur_addr   <= addr;
              busy       <= 1'b1;
              flash_cs_n <= 1'b0;
              flash_mosi <= 1'b0;
              sh         <= {7'h03, addr, 1'b0};
              div_cnt    <= '0;
              bit_cnt    <= '0;
              state      <= CMD;
            end
          end
          CMD, DATA: begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == RISE) begin
              flash_sck <= 1'b1;
              if (state == DATA) rx <= {rx[6:0], flash_miso};
            end
            if (div_cnt == FALL) begin
              flash_sck <= 1'b0;
              div_cnt   <= '0;
              bit_cnt   <= bit_cnt + 1'b1;
              if (state == CMD) begin
                // sh holds the bits still to send, MSB next
                flash_mosi <= sh[31];
                sh         <= {sh[30:0], 1'b0};
                if (bit_cnt == 5'd31) begin
                  flash_mosi <= 1'b0;
                  bit_cnt    <= '0;
                  state      <= DATA;
                end
              end else if (bit_cnt == 5'd7) begin
                dout       <= rx;
                data_valid <= 1'b1;
                busy       <= 1'b0;
                next_addr  <= cur_addr + 24'd1;
                state      <= HOLD;
              end
            end
          end
          HOLD: begin
            if (rd) begin
              busy     <= 1'b1;
              cur_addr <= addr;
              if (addr == next_addr) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                state   <= DATA;
              end else begin
                flash_cs_n <= 1'b1;
                pend       <= 1'b1;
                pend_addr  <= addr;
                cs_cnt     <= '0;
                state      <= DESEL;
              end
            end
          end
          DESEL: begin
            if (!rden) begin
              pend <= 1'b0;
              busy <= 1'b0;
            end
            if (cs_cnt == CS_LAST) begin
              if (pend && rden) begin
                cur_addr   <= pend_addr;
                flash_cs_n <= 1'b0;
                flash_mosi <= 1'b0;
                sh         <= {7'h03, pend_addr, 1'b0};
                div_cnt    <= '0;
                bit_cnt    <= '0;
                pend       <= 1'b0;
                state      <= CMD;
              end else begin
                busy  <= 1'b0;
                pend  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cs_cnt <= cs_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spiflash_reader.sv
// Directed bench for spiflash_reader with a behavioural mode-0 flash model.
module tb_spiflash_reader;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        rden;
  logic        rd;
  logic [23:0] addr;
  logic [7:0]  dout;
  logic        data_valid;
  logic        busy;
  logic        flash_cs_n;
  logic        flash_sck;
  logic        flash_mosi;
  logic        flash_miso = 1'b0;

  int vec  = 0;
  int errs = 0;

  spiflash_reader #(.CLK_DIV(2), .CS_HIGH_MIN(4)) dut (
    .clk28(clk28), .rst_n(rst_n), .rden(rden), .rd(rd), .addr(addr),
    .dout(dout), .data_valid(data_valid), .busy(busy),
    .flash_cs_n(flash_cs_n), .flash_sck(flash_sck),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #18 clk28 = ~clk28;

  // flash model: contents default to low address byte xor 0x5A
  logic [7:0]  mem [logic [23:0]];
  int          fbits = 0;
  logic [31:0] fcmd = '0;
  logic [23:0] faddr = '0;
  logic [31:0] cmds [$];

  function automatic logic [7:0] mem_at(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge flash_sck or posedge flash_cs_n) begin
    if (flash_cs_n) fbits = 0;
    else begin
      if (fbits < 32) fcmd = {fcmd[30:0], flash_mosi};
      fbits++;
      if (fbits == 32) begin
        faddr = fcmd[23:0];
        cmds.push_back(fcmd);
      end
    end
  end

  always @(negedge flash_sck) begin
    if (!flash_cs_n && fbits >= 32) begin
      int k;
      logic [7:0] b;
      k = fbits - 32;
      b = mem_at(faddr + 24'(k / 8));
      flash_miso = b[7 - (k % 8)];
    end
  end

  int hi_run = 0, last_high = 0, cs_falls = 0, dv_cnt = 0;
  always @(negedge clk28) begin
    if (flash_cs_n) hi_run++;
    else begin
      if (hi_run != 0) last_high = hi_run;
      hi_run = 0;
    end
    if (data_valid) dv_cnt++;
  end
  always @(negedge flash_cs_n) cs_falls++;

  // lat counts clocks with the rd-sampling edge as clock 1; 0 means timeout
  task automatic do_read(input logic [23:0] a, input bit spam, output int lat);
    @(negedge clk28);
    rd = 1'b1; addr = a; lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk28); #1;
      rd = 1'b0;
      if (data_valid) begin lat = i; break; end
      if (spam && (i % 7 == 3)) begin rd = 1'b1; addr = 24'h123456; end
    end
    rd = 1'b0;
  endtask

  task automatic cycle_rden();
    @(negedge clk28); rden = 1'b0;
    repeat (12) @(posedge clk28);
    @(negedge clk28); rden = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rden = 1'b0; rd = 1'b0; addr = '0;
    #50;
    vec++; if (flash_cs_n !== 1'b1) begin errs++; $display("FAIL reset_cs_n got %b want 1", flash_cs_n); end
    vec++; if (flash_sck !== 1'b0) begin errs++; $display("FAIL reset_sck got %b want 0", flash_sck); end
    vec++; if (flash_mosi !== 1'b0) begin errs++; $display("FAIL reset_mosi got %b want 0", flash_mosi); end
    vec++; if (dout !== 8'h00) begin errs++; $display("FAIL reset_dout got %h want 00", dout); end
    vec++; if ({data_valid, busy} !== 2'b00) begin errs++; $display("FAIL reset_dv_busy got %b want 00", {data_valid, busy}); end
    @(negedge clk28); rst_n = 1'b1;
    repeat (2) @(posedge clk28);
  endtask

  task automatic test_first();
    int lat;
    mem[24'h013256] = 8'hA5;
    @(negedge clk28); rden = 1'b1;
    do_read(24'h013256, 1'b0, lat);
    vec++; if (lat !== 161) begin errs++; $display("FAIL first_latency got %0d want 161", lat); end
    vec++; if (dout !== 8'hA5) begin errs++; $display("FAIL first_dout got %h want a5", dout); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL first_busy got %b want 0", busy); end
    vec++; if (cmds.size() != 1 || cmds[0] !== 32'h03013256) begin
      errs++; $display("FAIL first_cmd got n=%0d cmd=%h want n=1 cmd=03013256", cmds.size(), (cmds.size() > 0) ? cmds[0] : 32'h0);
    end
  endtask

  task automatic test_stream();
    int lat, f0, c0;
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk28); rden = 1'b0;
    repeat (12) @(posedge clk28);
    for (int i = 0; i < 4; i++) mem[24'h013256 + 24'(i)] = exp_b[i];
    f0 = cs_falls; c0 = cmds.size();
    @(negedge clk28); rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(24'h013256 + 24'(i), 1'b0, lat);
      vec++; if (lat !== ((i == 0) ? 161 : 33)) begin errs++; $display("FAIL stream_latency[%0d] got %0d want %0d", i, lat, (i == 0) ? 161 : 33); end
      vec++; if (dout !== exp_b[i]) begin errs++; $display("FAIL stream_dout[%0d] got %h want %h", i, dout, exp_b[i]); end
    end
    vec++; if (cs_falls - f0 != 1) begin errs++; $display("FAIL stream_cs_periods got %0d want 1", cs_falls - f0); end
    vec++; if (cmds.size() - c0 != 1) begin errs++; $display("FAIL stream_cmds got %0d want 1", cmds.size() - c0); end
    repeat (5) @(posedge clk28); #1;
    vec++; if (dout !== 8'h44 || flash_cs_n !== 1'b0) begin errs++; $display("FAIL stream_hold got dout=%h cs_n=%b want 44 0", dout, flash_cs_n); end
  endtask

  task automatic test_nonseq();
    int lat;
    mem[24'h020000] = 8'hC3;
    cycle_rden();
    do_read(24'h013256, 1'b0, lat);
    vec++; if (dout !== 8'h11) begin errs++; $display("FAIL nonseq_first_dout got %h want 11", dout); end
    do_read(24'h020000, 1'b0, lat);
    vec++; if (lat !== 165) begin errs++; $display("FAIL nonseq_latency got %0d want 165", lat); end
    vec++; if (dout !== 8'hC3) begin errs++; $display("FAIL nonseq_dout got %h want c3", dout); end
    vec++; if (last_high !== 4) begin errs++; $display("FAIL nonseq_cs_high got %0d want 4", last_high); end
    vec++; if (cmds[$] !== 32'h03020000) begin errs++; $display("FAIL nonseq_cmd got %h want 03020000", cmds[$]); end
  endtask

  task automatic test_abort();
    int lat, d0;
    for (int p = 0; p < 2; p++) begin
      cycle_rden();
      d0 = dv_cnt;
      @(negedge clk28); rd = 1'b1; addr = 24'h000100;
      @(posedge clk28); #1; rd = 1'b0;
      repeat ((p == 0) ? 40 : 140) @(posedge clk28);
      @(negedge clk28); rden = 1'b0;
      @(posedge clk28); #1;
      vec++; if ({flash_cs_n, flash_sck, busy} !== 3'b100) begin
        errs++; $display("FAIL abort%0d_outputs got cs_n,sck,busy=%b want 100", p, {flash_cs_n, flash_sck, busy});
      end
      repeat (200) @(posedge clk28);
      vec++; if (dv_cnt != d0) begin errs++; $display("FAIL abort%0d_no_valid got %0d strobes want 0", p, dv_cnt - d0); end
      @(negedge clk28); rden = 1'b1;
      do_read(24'h000100, 1'b0, lat);
      vec++; if (lat !== 161 || dout !== 8'h5A) begin
        errs++; $display("FAIL abort%0d_recover got lat=%0d dout=%h want 161 5a", p, lat, dout);
      end
    end
  endtask

  task automatic test_wrap();
    int lat, c0;
    mem[24'hFFFFFF] = 8'h77;
    mem[24'h000000] = 8'h88;
    cycle_rden();
    c0 = cmds.size();
    do_read(24'hFFFFFF, 1'b1, lat);
    vec++; if (lat !== 161 || dout !== 8'h77) begin errs++; $display("FAIL wrap_first got lat=%0d dout=%h want 161 77", lat, dout); end
    do_read(24'h000000, 1'b1, lat);
    vec++; if (lat !== 33 || dout !== 8'h88) begin errs++; $display("FAIL wrap_second got lat=%0d dout=%h want 33 88", lat, dout); end
    vec++; if (cmds.size() - c0 != 1) begin errs++; $display("FAIL wrap_cmds got %0d want 1", cmds.size() - c0); end
  endtask

  task automatic test_async_reset();
    int lat;
    cycle_rden();
    @(negedge clk28); rd = 1'b1; addr = 24'h013256;
    @(posedge clk28); #1; rd = 1'b0;
    repeat (140) @(posedge clk28);
    #3 rst_n = 1'b0;
    #1;
    vec++; if ({flash_cs_n, flash_sck, flash_mosi} !== 3'b100) begin
      errs++; $display("FAIL areset_pins got cs_n,sck,mosi=%b want 100", {flash_cs_n, flash_sck, flash_mosi});
    end
    vec++; if ({data_valid, busy} !== 2'b00 || dout !== 8'h00) begin
      errs++; $display("FAIL areset_outputs got dv,busy=%b dout=%h want 00 00", {data_valid, busy}, dout);
    end
    @(negedge clk28); rst_n = 1'b1;
    do_read(24'h013256, 1'b0, lat);
    vec++; if (lat !== 161 || dout !== 8'h11) begin errs++; $display("FAIL areset_recover got lat=%0d dout=%h want 161 11", lat, dout); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_stream();
    test_nonseq();
    test_abort();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/spiflash_reader.md
Name: spiflash_reader

Overview:
- Byte-stream reader for the configuration SPI flash. It issues READ (0x03) commands and returns bytes on a valid/ready-style handshake.
- Sits directly upstream of the memory initializer. It feeds ROM images from the flash offset into the copy engine, which writes them to SRAM through the memory controller while init_busy holds the CPU in reset.
- Sequential addresses stream without reissuing the command, so a full 128K ROM load is one continuous transfer.

Parameters:
- CLK_DIV, 2, SCK half-period in clk28 cycles (>=1); the default gives 7 MHz SCK.
- CS_HIGH_MIN, 4, minimum flash_cs_n high time in clk28 cycles between transactions (tSHSL).

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- rden  in  1  session enable; while low the flash is deselected
- rd  in  1  single-cycle read request for byte at addr
- addr  in  24  flash byte address, sampled with rd
- dout  out  8  read byte
- data_valid  out  1  one-cycle strobe, dout valid
- busy  out  1  request in progress; rd ignored
- flash_cs_n  out  1  chip select
- flash_sck  out  1  SPI clock, mode 0
- flash_mosi  out  1  command/address out
- flash_miso  in  1  data in

Behaviour:
- Single clock clk28; rst_n asynchronous active-low.
- Reset values: flash_cs_n=1, flash_sck=0, flash_mosi=0, dout=0, data_valid=0, busy=0, FSM=IDLE, next-address register=0.
- States:
  - IDLE
  - CMD: 32 bits, 0x03 then addr[23:0], MSB first
  - DATA: 8 bits
  - HOLD: cs low, awaiting next rd
  - DESEL: cs high, CS_HIGH_MIN count
- Bit timing:
  - Each bit takes 2*CLK_DIV clocks: sck low for CLK_DIV, then high for CLK_DIV.
  - mosi changes only while sck is low.
  - miso is sampled in the clock where sck rises.
  - sck returns low after the last bit of each byte.
- IDLE + rd + rden:
  - Latch addr, busy=1.
  - cs_n low the next cycle, enter CMD.
- CMD done -> DATA.
- DATA done:
  - dout updates and data_valid pulses for 1 cycle.
  - busy drops the same cycle.
  - Enter HOLD; next-address = addr+1 (24-bit wrap, 0xFFFFFF -> 0x000000).
- Latency:
  - First byte: data_valid at clock 1+80*CLK_DIV after rd is sampled (161 at default).
  - Streamed byte: 1+16*CLK_DIV (33 at default).
- HOLD + rd:
  - addr == next-address: enter DATA directly, no command.
  - Otherwise: go to DESEL, then automatically to CMD with the new addr; busy stays high throughout.
- DESEL:
  - cs_n=1 for exactly CS_HIGH_MIN clocks.
  - Then IDLE, or CMD if a pending request is latched.
- rd while busy=1: ignored, not queued.
- rd with rden=0: ignored.
- rden falls in any state:
  - Next cycle cs_n=1, sck=0, busy=0; no data_valid for the aborted byte.
  - Enter DESEL; pending request is discarded.
- rd in the same cycle rden rises: accepted.
- dout holds its value until the next data_valid.
- Async reset mid-transfer: all outputs return to reset values immediately; no partial data_valid.

Test Plan:
- Reset, rden=1, rd with addr=0x013256, flash model returns 0xA5:
  - mosi shows 0x03,0x01,0x32,0x56.
  - data_valid at clock 161, dout=0xA5, busy low the same cycle.
- Sequential stream of 4 bytes from 0x013256 (model bytes 0x11,0x22,0x33,0x44):
  - Single cs_n low period, no command reissue.
  - data_valid spacing 33 clocks, dout in order.
- Non-sequential rd in HOLD (0x013257 expected, 0x020000 given):
  - cs_n high for exactly 4 clocks, then a new 0x03 command with 0x020000.
  - Byte returned correctly.
- rden dropped mid-CMD and again mid-DATA:
  - cs_n high next cycle, sck=0, no data_valid, busy=0.
  - Subsequent rd after DESEL works normally.
- Wrap: stream reads 0xFFFFFF then 0x000000 treated as sequential; extra rd pulses while busy have no effect.
- rst_n asserted mid-DATA: outputs at reset values asynchronously; after release, a fresh rd completes in 161 clocks.
